matmul_seq_ctrl: RTL
====================

Name: matmul_seq_ctrl

Overview:
- Sequential controller and shared-MAC datapath computing signed S = A(4x4) x B(4x2) with one multiplier and one accumulator.
- Operands stream in over a valid/ready input channel; the 8 results stream out over a valid/ready output channel.
- It is the area-reduced, time-multiplexed counterpart of the team's combinational 4x4·4x2 signed matrix multiplier, with the same element and result widths.

Parameters:
- DW, 5, signed operand width (A and B elements)
- RW, 12, signed result/accumulator width; must be ≥ 2*DW+2
- ROWS, 4, rows of A and S
- KDIM, 4, columns of A = rows of B
- COLS, 2, columns of B and S

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts in_data this cycle
- in_data  in  DW  signed operand element
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts result
- out_data  out  RW  signed result element
- out_idx  out  3  result index = r*COLS+c (0..7)
- out_last  out  1  high with out_valid on index 7
- busy  out  1  high in COMPUTE and OUTPUT

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); rst high at a rising edge overrides all other activity.
- Reset values:
  - state = LOAD_A; all counters = 0; accumulator = 0.
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0.
  - Operand store is not cleared; it is fully rewritten before use.
- Reset mid-operation aborts the frame. Partial loads and pending results are discarded, and no out_valid is asserted until a new full frame has been loaded.
- Input transfer occurs on an edge where in_valid && in_ready.
- State LOAD_A:
  - in_ready = 1.
  - Accepts 16 A elements row-major: A[r][k], r = 0..3, k = 0..3.
  - After the 16th transfer, the next state is LOAD_B.
- State LOAD_B:
  - in_ready = 1.
  - Accepts 8 B elements row-major: B[k][c], c fastest.
  - On the 8th transfer, the next state is COMPUTE with r = 0, c = 0, k = 0, accumulator cleared.
- State COMPUTE:
  - in_ready = 0.
  - Each cycle performs acc <= acc + A[r][k]*B[k][c], with the product sign-extended to RW, and k increments.
  - At the edge where k = 3 is accumulated, the next state is OUTPUT. On that same edge out_valid <= 1, out_data <= final sum, out_idx <= 2r+c, out_last <= (idx == 7).
  - Latency: out_valid rises exactly 4 clocks after the edge that completed the previous input or output handshake.
- State OUTPUT:
  - out_data, out_idx and out_last are held stable while out_valid && !out_ready.
  - On handshake: out_valid <= 0.
  - If out_last, next state is LOAD_A.
  - Otherwise advance (c, then r), clear acc and k, and go to COMPUTE.
- Result order: S[0][0], S[0][1], S[1][0] … S[3][1] (idx 0..7).
- Throughput: with out_ready held high, each result occupies 5 cycles, i.e. 40 cycles from the last B transfer to the out_last handshake.
- Ignored signals:
  - in_valid outside the LOAD states is ignored; in_ready = 0 there.
  - out_ready without out_valid has no effect.
- Arithmetic: the product is 2*DW bits signed and the sum of 4 products fits in RW = 12 bits, so no saturation or wrap handling is needed. The range -1024..+1024 is required to pass exactly.
- Back-to-back frames: in_ready rises on the cycle after the out_last handshake. Input is never accepted while a result is pending.
- in_valid gaps (bubbles) during load are allowed; counters advance only on transfers.

Test Plan:
- Reset:
  - Assert rst for 2 cycles → out_valid = 0, busy = 0, in_ready = 1.
  - Reset asserted mid-COMPUTE → same values next cycle, and no spurious output.
- Nominal frame with out_ready = 1:
  - Stimulus: A rows [-1 -2 2 2], [2 1 2 3], [3 1 1 2], [4 -2 1 1]; B rows [6 5], [1 3], [3 2], [-7 3].
  - Required results idx 0..7: -16, -1, -2, 26, 8, 26, 18, 19.
  - out_last only on idx 7; first out_valid 4 clocks after the last B transfer.
- Extremes:
  - All A = -16, all B = -16 → all 8 results = 1024.
  - All A = -16, all B = 15 → all 8 results = -960.
- Output backpressure:
  - Hold out_ready = 0 for 6 cycles on idx 3 → out_data/out_idx stable, no further COMPUTE.
  - Release → remaining results correct and in order.
- Input bubbles and ignored input:
  - Toggle in_valid randomly during load → results identical to the nominal frame.
  - Drive in_valid = 1 during COMPUTE → no element consumed, in_ready = 0.
- Back-to-back frames:
  - Second frame (A = identity-like, diagonal 1, B = [1 2], [3 4], [5 6], [7 -8]) loaded immediately after out_last.
  - Required results: 1, 2, 3, 4, 5, 6, 7, -8.
  - in_ready rises 1 cycle after the out_last handshake.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_seq_ctrl
//  Description : Time-multiplexed signed matrix multiplier S = A(4x4) x B(4x2)
//                using one multiplier and one accumulator. Operands arrive on
//                a valid/ready input stream (A row-major, then B row-major);
//                the 8 results leave on a valid/ready output stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_seq_ctrl #(
    parameter int DW   = 5,
    parameter int RW   = 12,
    parameter int ROWS = 4,
    parameter int KDIM = 4,
    parameter int COLS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy
);

    localparam int c_NA  = ROWS * KDIM;
    localparam int c_NB  = KDIM * COLS;
    localparam int c_AW  = (c_NA > 1) ? $clog2(c_NA) : 1;
    localparam int c_BW  = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int c_LW  = (c_AW > c_BW) ? c_AW : c_BW;
    localparam int c_RBW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_KBW = (KDIM > 1) ? $clog2(KDIM) : 1;
    localparam int c_CBW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [1:0] c_LOAD_A  = 2'd0;
    localparam logic [1:0] c_LOAD_B  = 2'd1;
    localparam logic [1:0] c_COMPUTE = 2'd2;
    localparam logic [1:0] c_OUTPUT  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_LW-1:0]     r_ld_cnt;
    logic [c_RBW-1:0]    r_row;
    logic [c_CBW-1:0]    r_col;
    logic [c_KBW-1:0]    r_k;
    logic [RW-1:0]       r_acc;
    logic [DW-1:0]       r_a_mem [c_NA];
    logic [DW-1:0]       r_b_mem [c_NB];

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_ld_a_done;
    logic                w_ld_b_done;
    logic                w_k_last;
    logic                w_col_last;
    logic                w_row_last;
    logic [c_AW-1:0]     w_a_idx;
    logic [c_BW-1:0]     w_b_idx;
    logic [2:0]          w_out_idx;
    logic [DW-1:0]       w_a_op;
    logic [DW-1:0]       w_b_op;
    logic [2*DW-1:0]     w_a_ext;
    logic [2*DW-1:0]     w_b_ext;
    logic [2*DW-1:0]     w_prod;
    logic [RW-1:0]       w_prod_ext;
    logic [RW-1:0]       w_acc_sum;

    assign w_in_xfer   = in_valid && in_ready;
    assign w_out_xfer  = out_valid && out_ready;
    assign w_ld_a_done = (r_ld_cnt == c_LW'(c_NA - 1));
    assign w_ld_b_done = (r_ld_cnt == c_LW'(c_NB - 1));
    assign w_k_last    = (r_k == c_KBW'(KDIM - 1));
    assign w_col_last  = (r_col == c_CBW'(COLS - 1));
    assign w_row_last  = (r_row == c_RBW'(ROWS - 1));

    // Operand addressing: A[r][k] and B[k][c], both stored row-major
    assign w_a_idx   = c_AW'(int'(r_row) * KDIM + int'(r_k));
    assign w_b_idx   = c_BW'(int'(r_k) * COLS + int'(r_col));
    assign w_out_idx = 3'(int'(r_row) * COLS + int'(r_col));

    // Shared MAC: operands widened to 2*DW so the low half of the product is
    // the exact signed result, then sign-extended into the accumulator width
    assign w_a_op     = r_a_mem[w_a_idx];
    assign w_b_op     = r_b_mem[w_b_idx];
    assign w_a_ext    = {{DW{w_a_op[DW-1]}}, w_a_op};
    assign w_b_ext    = {{DW{w_b_op[DW-1]}}, w_b_op};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(RW - 2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_acc_sum  = r_acc + w_prod_ext;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_LOAD_A:  if (w_in_xfer && w_ld_a_done) w_next_state = c_LOAD_B;
            c_LOAD_B:  if (w_in_xfer && w_ld_b_done) w_next_state = c_COMPUTE;
            c_COMPUTE: if (w_k_last) w_next_state = c_OUTPUT;
            c_OUTPUT:  if (w_out_xfer) w_next_state = out_last ? c_LOAD_A : c_COMPUTE;
            default:   w_next_state = c_LOAD_A;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            c_LOAD_A, c_LOAD_B:  in_ready = 1'b1;
            c_COMPUTE, c_OUTPUT: busy     = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Operand store: not reset, always fully rewritten by a frame before use
    always_ff @(posedge clk) begin
        if (!rst && w_in_xfer) begin
            if (r_state == c_LOAD_A) begin
                r_a_mem[c_AW'(r_ld_cnt)] <= in_data;
            end else begin
                r_b_mem[c_BW'(r_ld_cnt)] <= in_data;
            end
        end
    end

    // Counters, accumulator and registered result channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_cnt  <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                c_LOAD_A: begin
                    if (w_in_xfer) r_ld_cnt <= w_ld_a_done ? '0 : r_ld_cnt + 1'b1;
                end
                c_LOAD_B: begin
                    if (w_in_xfer) begin
                        if (w_ld_b_done) begin
                            r_ld_cnt <= '0;
                            r_row    <= '0;
                            r_col    <= '0;
                            r_k      <= '0;
                            r_acc    <= '0;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + 1'b1;
                        end
                    end
                end
                c_COMPUTE: begin
                    r_acc <= w_acc_sum;
                    r_k   <= w_k_last ? '0 : r_k + 1'b1;
                    if (w_k_last) begin
                        out_valid <= 1'b1;
                        out_data  <= w_acc_sum;
                        out_idx   <= w_out_idx;
                        out_last  <= w_row_last && w_col_last;
                    end
                end
                c_OUTPUT: begin
                    // Row/column wrap to zero after the final result
                    if (w_out_xfer) begin
                        out_valid <= 1'b0;
                        r_acc     <= '0;
                        r_k       <= '0;
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= w_row_last ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: r_ld_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire
